morse_writer: RTL and testbench

//   Transmit side of the morse link. Accepts one ASCII character, encodes it into the
//   10-bit symbol word used by the morse reader, then plays it on morse_out as timed

---
 rtl/morse_writer.sv | 209 ++++++++++++++++++++
 tb/tb_morse_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_writer.sv
// Morse transmitter: encodes one ASCII character into a 10-bit symbol word and plays it
// on morse_out as timed marks and gaps.
module morse_writer #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DOT_UNITS  = 1,
    parameter int unsigned DASH_UNITS = 3,
    parameter int unsigned SYM_GAP    = 1,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned WORD_GAP   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii_in,
    input  logic       start,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       morse_out,
    output logic [9:0] code_out,
    output logic       done,
    output logic       err
);

    localparam int unsigned CycW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(TICK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StMark, StSgap, StLgap, StWgap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      char_q;
    logic [9:0]      code_q;
    logic [2:0]      ptr_q;
    logic [CycW-1:0] cyc_q;
    logic [7:0]      unit_q;
    logic            morse_q, done_q, err_q;
    logic            morse_d, done_d, err_d;

    // {valid, symbol count, symbols right-aligned with the earliest at the top, 1 = dash}
    function automatic logic [8:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        unique case (u)
            "A": lookup = {1'b1, 3'd2, 5'b00001};
            "B": lookup = {1'b1, 3'd4, 5'b01000};
            "C": lookup = {1'b1, 3'd4, 5'b01010};
            "D": lookup = {1'b1, 3'd3, 5'b00100};
            "E": lookup = {1'b1, 3'd1, 5'b00000};
            "F": lookup = {1'b1, 3'd4, 5'b00010};
            "G": lookup = {1'b1, 3'd3, 5'b00110};
            "H": lookup = {1'b1, 3'd4, 5'b00000};
            "I": lookup = {1'b1, 3'd2, 5'b00000};
            "J": lookup = {1'b1, 3'd4, 5'b00111};
            "K": lookup = {1'b1, 3'd3, 5'b00101};
            "L": lookup = {1'b1, 3'd4, 5'b00100};
            "M": lookup = {1'b1, 3'd2, 5'b00011};
            "N": lookup = {1'b1, 3'd2, 5'b00010};
            "O": lookup = {1'b1, 3'd3, 5'b00111};
            "P": lookup = {1'b1, 3'd4, 5'b00110};
            "Q": lookup = {1'b1, 3'd4, 5'b01101};
            "R": lookup = {1'b1, 3'd3, 5'b00010};
            "S": lookup = {1'b1, 3'd3, 5'b00000};
            "T": lookup = {1'b1, 3'd1, 5'b00001};
            "U": lookup = {1'b1, 3'd3, 5'b00001};
            "V": lookup = {1'b1, 3'd4, 5'b00001};
            "W": lookup = {1'b1, 3'd3, 5'b00011};
            "X": lookup = {1'b1, 3'd4, 5'b01001};
            "Y": lookup = {1'b1, 3'd4, 5'b01011};
            "Z": lookup = {1'b1, 3'd4, 5'b01100};
            "0": lookup = {1'b1, 3'd5, 5'b11111};
            "1": lookup = {1'b1, 3'd5, 5'b01111};
            "2": lookup = {1'b1, 3'd5, 5'b00111};
            "3": lookup = {1'b1, 3'd5, 5'b00011};
            "4": lookup = {1'b1, 3'd5, 5'b00001};
            "5": lookup = {1'b1, 3'd5, 5'b00000};
            "6": lookup = {1'b1, 3'd5, 5'b10000};
            "7": lookup = {1'b1, 3'd5, 5'b11000};
            "8": lookup = {1'b1, 3'd5, 5'b11100};
            "9": lookup = {1'b1, 3'd5, 5'b11110};
            default: lookup = 9'd0;
        endcase
    endfunction

    function automatic logic [9:0] encode(input logic [2:0] len, input logic [4:0] bits);
        encode = 10'd0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(len)) encode[2*i +: 2] = {1'b1, bits[i]};
        end
    endfunction

    logic [8:0] lk;
    logic       lk_valid;
    logic [2:0] lk_len;
    logic [9:0] lk_code;
    logic [3:0] sym_idx;
    logic       cur_dash;
    logic [7:0] state_len;
    logic       timed, tick_last, tdone;

    always_comb begin
        lk       = lookup(char_q);
        lk_valid = lk[8];
        lk_len   = lk[7:5];
        lk_code  = encode(lk_len, lk[4:0]);
        sym_idx  = {ptr_q, 1'b0};
        cur_dash = code_q[sym_idx];
    end

    always_comb begin
        state_len = 8'd1;
        unique case (state_q)
            StMark:  state_len = cur_dash ? 8'(DASH_UNITS) : 8'(DOT_UNITS);
            StSgap:  state_len = 8'(SYM_GAP);
            StLgap:  state_len = 8'(LETTER_GAP);
            StWgap:  state_len = 8'(WORD_GAP);
            default: state_len = 8'd1;
        endcase
        timed     = (state_q == StMark) || (state_q == StSgap) ||
                    (state_q == StLgap) || (state_q == StWgap);
        tick_last = (cyc_q == CycLast);
        tdone     = timed && tick_last && (unit_q == state_len - 8'd1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic; abort wins over any timer transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (ascii_in == 8'h20) ? StWgap : StLoad;
            end
            StLoad: begin
                if (abort)         state_d = StIdle;
                else if (lk_valid) state_d = StMark;
                else               state_d = StIdle;
            end
            StMark: begin
                if (abort)      state_d = StIdle;
                else if (tdone) state_d = (ptr_q != 3'd0) ? StSgap : StLgap;
            end
            StSgap: begin
                if (abort)      state_d = StIdle;
                else if (tdone) state_d = StMark;
            end
            StLgap, StWgap: begin
                if (abort || tdone) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; morse_out is registered from the current state so it rises one edge after LOAD
    always_comb begin
        ready   = (state_q == StIdle);
        busy    = ~ready;
        morse_d = (state_q == StMark) && !abort;
        done_d  = tdone && !abort && ((state_q == StLgap) || (state_q == StWgap));
        err_d   = (state_q == StLoad) && !abort && !lk_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q  <= 8'd0;
            code_q  <= 10'd0;
            ptr_q   <= 3'd0;
            cyc_q   <= '0;
            unit_q  <= 8'd0;
            morse_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            morse_q <= morse_d;
            done_q  <= done_d;
            err_q   <= err_d;

            if (state_q == StIdle && start) begin
                char_q <= ascii_in;
                if (ascii_in == 8'h20) code_q <= 10'd0;
            end

            if (state_q == StLoad && !abort) begin
                code_q <= lk_valid ? lk_code : 10'd0;
                ptr_q  <= lk_len - 3'd1;
            end

            if (state_q == StSgap && tdone && !abort) ptr_q <= ptr_q - 3'd1;

            if (state_d != state_q || !timed) begin
                cyc_q  <= '0;
                unit_q <= 8'd0;
            end else if (tick_last) begin
                cyc_q  <= '0;
                unit_q <= unit_q + 8'd1;
            end else begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    assign morse_out = morse_q;
    assign code_out  = code_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_morse_writer.sv
// Scoreboard bench for morse_writer: a string-table Morse model predicts code word,
// completion pulse and per-cycle morse_out waveform for each accepted character.
module tb_morse_writer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii_in = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready, busy, morse_out, done, err;
    logic [9:0] code_out;

    morse_writer #(.TICK_DIV(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ascii_in (ascii_in),
        .start    (start),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .morse_out(morse_out),
        .code_out (code_out),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0]   code;
        bit           dn;
        bit           er;
        int           len;
        logic [127:0] wave;
    } exp_t;

    exp_t sb[$];

    string morse_tbl[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
        "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sym_index(input logic [7:0] c);
        if (c >= "A" && c <= "Z") return int'(c) - 65;
        if (c >= "a" && c <= "z") return int'(c) - 97;
        if (c >= "0" && c <= "9") return 26 + int'(c) - 48;
        return -1;
    endfunction

    // Waveform index = cycles after the accepting edge; the last entry is the cycle ready returns
    function automatic exp_t model(input logic [7:0] c, input int abort_at);
        exp_t  e;
        int    idx, pos, n;
        string s;
        e.code = 10'd0; e.dn = 1'b0; e.er = 1'b0; e.wave = '0; e.len = 0;
        idx = sym_index(c);
        if (c == 8'h20) begin
            e.dn  = 1'b1;
            e.len = 7 * T + 1;
        end else if (idx < 0) begin
            e.er  = 1'b1;
            e.len = 2;
        end else begin
            s   = morse_tbl[idx];
            pos = 2;
            for (int i = 0; i < s.len(); i++) begin
                e.code = (e.code << 2) | ((s[i] == "-") ? 10'd3 : 10'd2);
                n = ((s[i] == "-") ? 3 : 1) * T;
                for (int j = 0; j < n; j++) e.wave[pos + j] = 1'b1;
                pos += n;
                if (i != s.len() - 1) pos += T;
            end
            pos  += 3 * T;
            e.dn  = 1'b1;
            e.len = pos;
        end
        if (abort_at >= 0) begin
            e.dn  = 1'b0;
            e.len = abort_at + 2;
            for (int i = abort_at + 1; i < 128; i++) e.wave[i] = 1'b0;
        end
        return e;
    endfunction

    // Monitor: start capture on accept, compare against the scoreboard when ready returns
    logic         capturing = 1'b0;
    int           cnt = 0;
    logic [127:0] cap = '0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && start && ready) begin
                capturing = 1'b1;
                cnt = 0;
                cap = '0;
            end
            @(negedge clk);
            if (!rst_n) begin
                if (capturing && sb.size() > 0) void'(sb.pop_front());
                capturing = 1'b0;
            end else if (capturing) begin
                cap[cnt] = morse_out;
                if (ready) begin
                    capturing = 1'b0;
                    if (sb.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("code_out", code_out, e.code);
                        chk("done", done, e.dn);
                        chk("err", err, e.er);
                        chk("length", cnt + 1, e.len);
                        chk("waveform", cap, e.wave);
                    end
                end else begin
                    cnt++;
                    if (cnt >= 128) begin
                        chk("ready_timeout", 0, 1);
                        capturing = 1'b0;
                        if (sb.size() > 0) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("wait_ready_timeout", 0, 1);
    endtask

    // Called at a negedge with the DUT idle
    task automatic send(input logic [7:0] c, input int abort_at, input bit poke,
                        input bit abort_with_start);
        exp_t e;
        int   j;
        wait_ready();
        e = model(c, abort_at);
        sb.push_back(e);
        start    = 1'b1;
        ascii_in = c;
        abort    = abort_with_start;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        ascii_in = 8'($urandom);
        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end else if (poke && e.len > 4) begin
            j = $urandom_range(1, e.len - 3);
            repeat (j - 1) @(negedge clk);
            start    = 1'b1;
            ascii_in = 8'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        wait_ready();
    endtask

    function automatic logic [7:0] rand_char();
        int          k;
        logic [7:0]  c;
        k = $urandom_range(0, 5);
        case (k)
            0: c = 8'($urandom_range(65, 90));
            1: c = 8'($urandom_range(97, 122));
            2: c = 8'($urandom_range(48, 57));
            3: c = 8'h20;
            default: begin
                c = 8'($urandom);
                while (sym_index(c) >= 0 || c == 8'h20) c = 8'($urandom);
            end
        endcase
        return c;
    endfunction

    initial begin
        logic [7:0] c;
        exp_t       e;
        int         k;

        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_morse", morse_out, 0);
        chk("reset_code", code_out, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send("E", -1, 1'b0, 1'b0);
        send("a", -1, 1'b0, 1'b0);
        send("0", -1, 1'b0, 1'b0);
        send(" ", -1, 1'b0, 1'b0);
        send("#", -1, 1'b0, 1'b0);
        send("A", -1, 1'b1, 1'b0);
        send("A", 14, 1'b0, 1'b0);   // abort inside the dash
        abort = 1'b1;                // abort while idle must do nothing
        @(negedge clk);
        abort = 1'b0;
        send("T", -1, 1'b0, 1'b1);   // abort together with start in idle: accepted

        for (int i = 0; i < 30; i++) begin
            c = rand_char();
            e = model(c, -1);
            k = -1;
            if (!e.er && $urandom_range(0, 3) == 0) k = $urandom_range(2, e.len - 2);
            send(c, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a mark
        wait_ready();
        sb.push_back(model("E", -1));
        start    = 1'b1;
        ascii_in = "E";
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mark_before_reset", morse_out, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_morse", morse_out, 0);
        chk("async_reset_ready", ready, 1);
        chk("async_reset_code", code_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", ready, 1);
        send("E", -1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
